// File: rtl/dsp_param_frame_rx.sv
// Receives a DSP parameter frame from the shared RAM on a debounced XINT1 fall.
// The frame is checksum-validated and then committed to params_flat as one block.
module dsp_param_frame_rx #(
    parameter int unsigned    DW         = 16,
    parameter int unsigned    AW         = 10,
    parameter int unsigned    NUM_WORDS  = 31,
    parameter logic [AW-1:0]  BASE_ADDR  = 10'h010,
    parameter int unsigned    DEB_LEN    = 5,
    parameter int unsigned    DELAY_TIME = 100,
    parameter int unsigned    WAIT_TMO   = 4096
) (
    input  logic                    clk_100M,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    XINT1,
    input  logic                    dsp_w,
    input  logic [DW-1:0]           ram_dout,
    output logic [AW-1:0]           addr_r,
    output logic [NUM_WORDS*DW-1:0] params_flat,
    output logic                    frame_ok,
    output logic                    sum_err,
    output logic                    timeout_err,
    output logic                    busy,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             err_cnt
);

    localparam int unsigned DB_W  = $clog2(DEB_LEN + 1);
    localparam int unsigned DT_W  = $clog2(DELAY_TIME + 1);
    localparam int unsigned TMO_W = $clog2(WAIT_TMO + 1);
    localparam int unsigned RD_W  = $clog2(NUM_WORDS + 2);
    localparam int unsigned IX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // The last read address must fit in the RAM without wrapping.
    if (int'(BASE_ADDR) + NUM_WORDS >= (1 << AW)) begin : g_addr_range_check
        $error("dsp_param_frame_rx: BASE_ADDR + NUM_WORDS exceeds the address space");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_WAIT_W,
        ST_READ,
        ST_CHECK
    } state_t;

    state_t                  state, state_next;
    logic [1:0]              xint_sync;
    logic                    xint_filt;
    logic [DB_W-1:0]         deb_cnt;
    logic [DT_W-1:0]         dly_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [RD_W-1:0]         rd_cnt;
    logic [DW-1:0]           sum;
    logic [DW-1:0]           checksum;
    logic [NUM_WORDS*DW-1:0] staging;
    logic                    filt_fall_c;
    logic                    read_start_c;
    logic                    cap_word_c;
    logic                    cap_sum_c;
    logic                    commit_c;
    logic                    bad_c;
    logic                    tmo_c;

    // Filtered level is about to change 1->0 on this edge.
    assign filt_fall_c = xint_filt & ~xint_sync[1] & (deb_cnt == DB_W'(DEB_LEN - 1));

    // Two-flop synchronizer followed by the consecutive-sample debounce filter.
    always_ff @(posedge clk_100M) begin
        if (!reset_n) begin
            xint_sync <= 2'b11;
            xint_filt <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            xint_sync <= {xint_sync[0], XINT1};
            if (xint_sync[1] == xint_filt) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DB_W'(DEB_LEN - 1)) begin
                xint_filt <= xint_sync[1];
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DB_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_100M) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        state_next   = state;
        read_start_c = 1'b0;
        cap_word_c   = 1'b0;
        cap_sum_c    = 1'b0;
        commit_c     = 1'b0;
        bad_c        = 1'b0;
        tmo_c        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (filt_fall_c && enable) begin
                    state_next = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dly_cnt == DT_W'(DELAY_TIME - 1)) begin
                    state_next = ST_WAIT_W;
                end
            end
            ST_WAIT_W: begin
                if (!dsp_w) begin
                    state_next   = ST_READ;
                    read_start_c = 1'b1;
                end else if (tmo_cnt == TMO_W'(WAIT_TMO - 1)) begin
                    state_next = ST_IDLE;
                    tmo_c      = 1'b1;
                end
            end
            ST_READ: begin
                if (rd_cnt == RD_W'(NUM_WORDS + 1)) begin
                    cap_sum_c  = 1'b1;
                    state_next = ST_CHECK;
                end else if (rd_cnt != '0) begin
                    cap_word_c = 1'b1;
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (checksum == ~sum) begin
                    commit_c = 1'b1;
                end else begin
                    bad_c = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-state cycle counters, cleared whenever their state is left.
    always_ff @(posedge clk_100M) begin
        if (!reset_n) begin
            dly_cnt <= '0;
            tmo_cnt <= '0;
            rd_cnt  <= '0;
        end else begin
            dly_cnt <= (state == ST_DELAY)  ? dly_cnt + DT_W'(1)  : '0;
            tmo_cnt <= (state == ST_WAIT_W) ? tmo_cnt + TMO_W'(1) : '0;
            rd_cnt  <= (state == ST_READ)   ? rd_cnt + RD_W'(1)   : '0;
        end
    end

    // Staging words; data for address BASE_ADDR+k arrives at rd_cnt == k+1.
    always_ff @(posedge clk_100M) begin
        if (cap_word_c) begin
            staging[32'(IX_W'(rd_cnt - RD_W'(1))) * DW +: DW] <= ram_dout;
        end
    end

    // Address sequencing, checksum accumulation, commit and statistics.
    always_ff @(posedge clk_100M) begin
        if (!reset_n) begin
            addr_r      <= BASE_ADDR;
            params_flat <= '0;
            frame_ok    <= 1'b0;
            sum_err     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
            sum         <= '0;
            checksum    <= '0;
        end else begin
            frame_ok    <= commit_c;
            timeout_err <= tmo_c;
            busy        <= (state_next != ST_IDLE);

            if (read_start_c || state == ST_CHECK) begin
                addr_r <= BASE_ADDR;
            end else if (state == ST_READ && rd_cnt < RD_W'(NUM_WORDS)) begin
                addr_r <= addr_r + AW'(1);
            end

            if (read_start_c) begin
                sum <= '0;
            end else if (cap_word_c) begin
                sum <= sum + ram_dout;
            end

            if (cap_sum_c) begin
                checksum <= ram_dout;
            end

            if (commit_c) begin
                params_flat <= staging;
                frame_cnt   <= frame_cnt + 16'd1;
                sum_err     <= 1'b0;
            end else if (bad_c) begin
                sum_err <= 1'b1;
            end

            if ((bad_c || tmo_c) && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_param_frame_rx.sv
// Randomized frame bench for dsp_param_frame_rx with a frame-level reference model.
module tb_dsp_param_frame_rx;

    localparam int unsigned  DW   = 16;
    localparam int unsigned  AW   = 10;
    localparam int unsigned  NW   = 31;
    localparam logic [AW-1:0] BASE = 10'h010;
    localparam int unsigned  DT   = 100;
    localparam int unsigned  TMO  = 4096;
    localparam int unsigned  DEB  = 5;

    logic              clk_100M = 1'b0;
    logic              reset_n  = 1'b0;
    logic              enable   = 1'b0;
    logic              XINT1    = 1'b1;
    logic              dsp_w    = 1'b0;
    logic [DW-1:0]     ram_dout;
    logic [AW-1:0]     addr_r;
    logic [NW*DW-1:0]  params_flat;
    logic              frame_ok, sum_err, timeout_err, busy;
    logic [15:0]       frame_cnt, err_cnt;

    dsp_param_frame_rx dut (
        .clk_100M    (clk_100M),
        .reset_n     (reset_n),
        .enable      (enable),
        .XINT1       (XINT1),
        .dsp_w       (dsp_w),
        .ram_dout    (ram_dout),
        .addr_r      (addr_r),
        .params_flat (params_flat),
        .frame_ok    (frame_ok),
        .sum_err     (sum_err),
        .timeout_err (timeout_err),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk_100M = ~clk_100M;

    // Shared RAM with one-cycle registered read.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk_100M) ram_dout <= ram[addr_r];

    // Event monitor: counts pulses and timestamps frame milestones.
    int cyc = 0, mon_ok = 0, mon_tmo = 0, mon_rise = 0, mon_off_base = 0, mon_max_addr = 0;
    int ok_cyc = 0, tmo_cyc = 0, rise_cyc = 0, addr1_cyc = 0;
    bit busy_q = 1'b0;
    always @(negedge clk_100M) begin
        cyc++;
        if (busy === 1'b1 && !busy_q) begin mon_rise++; rise_cyc = cyc; end
        busy_q = (busy === 1'b1);
        if (frame_ok === 1'b1) begin mon_ok++; ok_cyc = cyc; end
        if (timeout_err === 1'b1) begin mon_tmo++; tmo_cyc = cyc; end
        if (addr_r === BASE + AW'(1)) addr1_cyc = cyc;
        if (reset_n && addr_r !== BASE) mon_off_base++;
        if (int'(addr_r) > mon_max_addr) mon_max_addr = int'(addr_r);
    end

    // Reference model state.
    logic [DW-1:0]    frame_words [NW];
    logic [DW-1:0]    frame_chk;
    logic [NW*DW-1:0] exp_params;
    logic [15:0]      exp_fc, exp_ec;
    logic             exp_se;
    bit               exp_good;

    int tests_run = 0;
    int failures  = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100M);
        #1;
    endtask

    task automatic model_reset();
        exp_params = '0;
        exp_fc     = '0;
        exp_ec     = '0;
        exp_se     = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        model_reset();
        tick(1);
    endtask

    // mode 0: random good, 1: random bad, 2: words k+1 good, 3: words k+1 checksum 0
    task automatic load_frame(input int mode);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < NW; k++) begin
            frame_words[k] = (mode >= 2) ? DW'(k + 1) : DW'($urandom);
            s = s + frame_words[k];
            ram[AW'(int'(BASE) + k)] = frame_words[k];
        end
        case (mode)
            0, 2:    frame_chk = ~s;
            1:       frame_chk = ~s ^ DW'($urandom_range(1, 65535));
            default: frame_chk = '0;
        endcase
        ram[AW'(int'(BASE) + NW)] = frame_chk;
    endtask

    // Frame outcome: commit when checksum equals the complement of the word sum.
    task automatic model_apply();
        int total;
        total = 0;
        for (int k = 0; k < NW; k++) total += int'(frame_words[k]);
        exp_good = (int'(frame_chk) == (65535 - (total % 65536)));
        if (exp_good) begin
            for (int k = 0; k < NW; k++) exp_params[k*DW +: DW] = frame_words[k];
            exp_fc = 16'((int'(exp_fc) + 1) % 65536);
            exp_se = 1'b0;
        end else begin
            exp_se = 1'b1;
            if (exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
        end
    endtask

    task automatic pulse_xint(input int n);
        XINT1 = 1'b0;
        tick(n);
        XINT1 = 1'b1;
        tick(DEB + 4);
    endtask

    // Trigger one frame and wait (bounded) until the receiver returns to idle.
    task automatic run_frame(output bit done);
        int r0;
        r0   = mon_rise;
        done = 1'b0;
        pulse_xint(12);
        for (int i = 0; i < 600; i++) begin
            if (mon_rise != r0 && !busy) begin done = 1'b1; break; end
            tick(1);
        end
        tick(2);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (addr_r !== BASE) begin failures++; $display("FAIL reset_addr got %h want %h", addr_r, BASE); end
        tests_run++; if (params_flat !== '0) begin failures++; $display("FAIL reset_params got %h want 0", params_flat); end
        tests_run++; if (frame_ok !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got %b%b want 00", frame_ok, timeout_err); end
        tests_run++; if (sum_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags got %b%b want 00", sum_err, busy); end
        tests_run++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnts got %h %h want 0 0", frame_cnt, err_cnt); end
    endtask

    task automatic test_good_frame();
        bit done;
        int ok0;
        do_reset();
        load_frame(2);
        model_apply();
        ok0 = mon_ok;
        run_frame(done);
        tests_run++; if (!done) begin failures++; $display("FAIL good_done got timeout want idle"); end
        tests_run++; if (mon_ok - ok0 != 1) begin failures++; $display("FAIL good_ok_pulses got %0d want 1", mon_ok - ok0); end
        tests_run++; if (params_flat[0 +: DW] !== 16'd1) begin failures++; $display("FAIL good_word0 got %h want 0001", params_flat[0 +: DW]); end
        tests_run++; if (params_flat[30*DW +: DW] !== 16'd31) begin failures++; $display("FAIL good_word30 got %h want 001f", params_flat[30*DW +: DW]); end
        tests_run++; if (params_flat !== exp_params) begin failures++; $display("FAIL good_params got %h want %h", params_flat, exp_params); end
        tests_run++; if (sum_err !== 1'b0 || frame_cnt !== 16'd1) begin failures++; $display("FAIL good_status got se=%b fc=%h want se=0 fc=1", sum_err, frame_cnt); end
        tests_run++; if (addr1_cyc - rise_cyc != int'(DT) + 2) begin failures++; $display("FAIL good_start_latency got %0d want %0d", addr1_cyc - rise_cyc, DT + 2); end
        tests_run++; if (ok_cyc - addr1_cyc != int'(NW) + 2) begin failures++; $display("FAIL good_read_latency got %0d want %0d", ok_cyc - addr1_cyc, NW + 2); end
        tests_run++; if (mon_max_addr != int'(BASE) + int'(NW)) begin failures++; $display("FAIL good_max_addr got %0d want %0d", mon_max_addr, int'(BASE) + NW); end
    endtask

    task automatic test_bad_then_good();
        bit done;
        int ok0;
        do_reset();
        load_frame(3);
        model_apply();
        ok0 = mon_ok;
        run_frame(done);
        tests_run++; if (!done || mon_ok != ok0) begin failures++; $display("FAIL bad_no_commit got done=%b ok=%0d want done=1 ok=0", done, mon_ok - ok0); end
        tests_run++; if (sum_err !== 1'b1 || err_cnt !== 16'd1) begin failures++; $display("FAIL bad_status got se=%b ec=%h want se=1 ec=1", sum_err, err_cnt); end
        tests_run++; if (params_flat !== '0) begin failures++; $display("FAIL bad_params got %h want 0", params_flat); end
        load_frame(0);
        model_apply();
        run_frame(done);
        tests_run++; if (sum_err !== 1'b0 || frame_cnt !== 16'd1 || err_cnt !== 16'd1) begin failures++; $display("FAIL recover_status got se=%b fc=%h ec=%h want 0 1 1", sum_err, frame_cnt, err_cnt); end
        tests_run++; if (params_flat !== exp_params) begin failures++; $display("FAIL recover_params got %h want %h", params_flat, exp_params); end
    endtask

    task automatic test_random_frames();
        bit done;
        int ok0;
        for (int n = 0; n < 8; n++) begin
            load_frame(int'($urandom_range(0, 1)));
            model_apply();
            ok0 = mon_ok;
            run_frame(done);
            tests_run++; if (!done || (mon_ok - ok0) != int'(exp_good)) begin failures++; $display("FAIL rand%0d_ok got done=%b ok=%0d want %0d", n, done, mon_ok - ok0, exp_good); end
            tests_run++; if (params_flat !== exp_params) begin failures++; $display("FAIL rand%0d_params got %h want %h", n, params_flat, exp_params); end
            tests_run++; if (frame_cnt !== exp_fc || err_cnt !== exp_ec || sum_err !== exp_se) begin failures++; $display("FAIL rand%0d_status got fc=%h ec=%h se=%b want fc=%h ec=%h se=%b", n, frame_cnt, err_cnt, sum_err, exp_fc, exp_ec, exp_se); end
        end
    endtask

    task automatic test_timeout();
        int t0, off0, ok0;
        t0   = mon_tmo;
        off0 = mon_off_base;
        ok0  = mon_ok;
        dsp_w = 1'b1;
        pulse_xint(12);
        tick(5000);
        dsp_w = 1'b0;
        if (exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
        tick(4);
        tests_run++; if (mon_tmo - t0 != 1) begin failures++; $display("FAIL tmo_pulses got %0d want 1", mon_tmo - t0); end
        tests_run++; if (tmo_cyc - rise_cyc != int'(DT + TMO)) begin failures++; $display("FAIL tmo_latency got %0d want %0d", tmo_cyc - rise_cyc, DT + TMO); end
        tests_run++; if (mon_off_base != off0 || mon_ok != ok0) begin failures++; $display("FAIL tmo_no_read got reads=%0d ok=%0d want 0 0", mon_off_base - off0, mon_ok - ok0); end
        tests_run++; if (err_cnt !== exp_ec || sum_err !== exp_se || busy !== 1'b0) begin failures++; $display("FAIL tmo_status got ec=%h se=%b busy=%b want ec=%h se=%b busy=0", err_cnt, sum_err, busy, exp_ec, exp_se); end
        tests_run++; if (params_flat !== exp_params) begin failures++; $display("FAIL tmo_params got %h want %h", params_flat, exp_params); end
    endtask

    task automatic test_glitch_and_retrigger();
        int r0, ok0;
        bit seen;
        r0 = mon_rise;
        pulse_xint(3);
        tick(300);
        tests_run++; if (mon_rise != r0) begin failures++; $display("FAIL glitch_ignored got starts=%0d want 0", mon_rise - r0); end
        load_frame(0);
        model_apply();
        r0  = mon_rise;
        ok0 = mon_ok;
        XINT1 = 1'b0;
        tick(12);
        XINT1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (addr_r > BASE + AW'(2)) begin seen = 1'b1; break; end
            tick(1);
        end
        tests_run++; if (!seen) begin failures++; $display("FAIL retrig_read got no read want read"); end
        pulse_xint(12);
        tick(400);
        tests_run++; if (mon_ok - ok0 != 1 || mon_rise - r0 != 1) begin failures++; $display("FAIL retrig_one_frame got ok=%0d starts=%0d want 1 1", mon_ok - ok0, mon_rise - r0); end
        tests_run++; if (frame_cnt !== exp_fc || params_flat !== exp_params) begin failures++; $display("FAIL retrig_status got fc=%h want %h", frame_cnt, exp_fc); end
    endtask

    task automatic test_enable();
        int r0;
        r0 = mon_rise;
        enable = 1'b0;
        pulse_xint(12);
        tick(300);
        enable = 1'b1;
        tests_run++; if (mon_rise != r0 || busy !== 1'b0) begin failures++; $display("FAIL disabled_ignored got starts=%0d want 0", mon_rise - r0); end
    endtask

    task automatic test_reset_mid_frame();
        bit seen, done;
        int ok0;
        load_frame(0);
        ok0 = mon_ok;
        XINT1 = 1'b0;
        tick(12);
        XINT1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (addr_r == BASE + AW'(10)) begin seen = 1'b1; break; end
            tick(1);
        end
        tests_run++; if (!seen) begin failures++; $display("FAIL midrst_reach got no word10 want word10"); end
        reset_n = 1'b0;
        tick(2);
        tests_run++; if (addr_r !== BASE || busy !== 1'b0 || frame_ok !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got addr=%h busy=%b want %h 0", addr_r, busy, BASE); end
        tests_run++; if (params_flat !== '0 || sum_err !== 1'b0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL midrst_state got fc=%h ec=%h se=%b want 0", frame_cnt, err_cnt, sum_err); end
        reset_n = 1'b1;
        model_reset();
        tick(10);
        tests_run++; if (mon_ok != ok0) begin failures++; $display("FAIL midrst_no_commit got ok=%0d want 0", mon_ok - ok0); end
        load_frame(0);
        model_apply();
        run_frame(done);
        tests_run++; if (!done || frame_cnt !== 16'd1 || params_flat !== exp_params) begin failures++; $display("FAIL midrst_next_frame got fc=%h want 1", frame_cnt); end
    endtask

    task automatic test_counter_limits();
        bit done;
        force dut.frame_cnt = 16'hFFFF;
        tick(1);
        release dut.frame_cnt;
        exp_fc = 16'hFFFF;
        tick(1);
        tests_run++; if (frame_cnt !== 16'hFFFF) begin failures++; $display("FAIL preload_fc got %h want ffff", frame_cnt); end
        load_frame(0);
        model_apply();
        run_frame(done);
        tests_run++; if (frame_cnt !== exp_fc || frame_cnt !== 16'h0000) begin failures++; $display("FAIL fc_wrap got %h want 0000", frame_cnt); end
        force dut.err_cnt = 16'hFFFF;
        tick(1);
        release dut.err_cnt;
        exp_ec = 16'hFFFF;
        tick(1);
        load_frame(1);
        model_apply();
        run_frame(done);
        tests_run++; if (err_cnt !== 16'hFFFF || sum_err !== 1'b1) begin failures++; $display("FAIL ec_saturate got ec=%h se=%b want ffff 1", err_cnt, sum_err); end
    endtask

    initial begin
        for (int a = 0; a < 2**AW; a++) ram[a] = '0;
        enable = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_then_good();
        test_random_frames();
        test_timeout();
        test_glitch_and_retrigger();
        test_enable();
        test_reset_mid_frame();
        test_counter_limits();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #2ms;
        $display("FAIL watchdog got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
